// File: rtl/hc245_bus_seq.sv
// ---------------------------------------------------------------------------
// hc245_bus_seq
//
// Bus sequencer placed directly in front of an HC245 octal transceiver.
// A valid/ready byte request is turned into the transceiver's DIR (p1) and
// OE_n (p19) controls. The A side (p2..p9) is driven through an external
// tri-state, or sampled from it. Every transaction walks
// IDLE -> SETUP -> ACCESS -> TURN -> IDLE, so the A-side bus is never driven
// from both ends. Each transaction returns exactly one rsp_valid pulse.
//
// Parameters
//   SETUP_CYC   cycles with DIR/A data settled and OE_n high before enable
//   ACCESS_CYC  cycles with OE_n low
//   TURN_CYC    dead cycles with OE_n high before returning to IDLE
//   (each legal in 1..255)
//
// Ports
//   clk        system clock, all state on the rising edge
//   rst        synchronous reset, active high
//   req_valid  request present
//   req_ready  block can accept a request (IDLE only)
//   req_write  1 = write (A->B), 0 = read (B->A)
//   req_wdata  write byte, bit7 -> p2 ... bit0 -> p9
//   rsp_valid  one-cycle completion pulse (first TURN cycle)
//   rsp_rdata  last byte read from the A side
//   dir        to HC245 p1 (1 = A->B, 0 = B->A)
//   oe_n       to HC245 p19, active low
//   a_out      A-side drive data
//   a_oe       enable for the top-level tri-state driving a_out onto p2..p9
//   a_in       A-side pin sample
// ---------------------------------------------------------------------------
module hc245_bus_seq #(
    parameter int SETUP_CYC  = 1,
    parameter int ACCESS_CYC = 2,
    parameter int TURN_CYC   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       dir,
    output logic       oe_n,
    output logic [7:0] a_out,
    output logic       a_oe,
    input  logic [7:0] a_in
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        TURN
    } state_t;

    // Each phase loads the shared counter with (length - 1). The phase ends
    // on the edge where the counter reads zero.
    localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC - 1);
    localparam logic [7:0] ACCESS_LD = 8'(ACCESS_CYC - 1);
    localparam logic [7:0] TURN_LD   = 8'(TURN_CYC - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic       cnt_zero;
    logic       accept;
    logic       access_end;
    logic       turn_end;

    assign cnt_zero   = (cnt == 8'd0);
    assign accept     = (state == IDLE) && req_valid;
    assign access_end = (state == ACCESS) && cnt_zero;
    assign turn_end   = (state == TURN) && cnt_zero;

    // State register and phase counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic. Request inputs are only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = SETUP;
                    cnt_nxt   = SETUP_LD;
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    state_nxt = ACCESS;
                    cnt_nxt   = ACCESS_LD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            ACCESS: begin
                if (cnt_zero) begin
                    state_nxt = TURN;
                    cnt_nxt   = TURN_LD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            TURN: begin
                if (cnt_zero) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    // Outputs decoded from the state.
    // rsp_valid marks the first TURN cycle, where the counter still holds its
    // load value. req_ready is masked by rst so that nothing looks accepted
    // while reset is held.
    always_comb begin
        req_ready = (state == IDLE) && !rst;
        oe_n      = (state != ACCESS);
        rsp_valid = (state == TURN) && (cnt == TURN_LD);
    end

    // Transceiver direction, A-side drive and read capture.
    // dir doubles as the latched write flag for the whole transaction.
    // It only moves on the accept edge, where oe_n is high on both sides.
    // a_oe is raised together with dir, so it can never be 1 while dir is 0.
    // On a write, a_oe is held through TURN so that B still sees valid data
    // after OE_n rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            dir       <= 1'b0;
            a_oe      <= 1'b0;
            a_out     <= 8'h00;
            rsp_rdata <= 8'h00;
        end else begin
            if (accept) begin
                dir   <= req_write;
                a_out <= req_wdata;
                a_oe  <= req_write;
            end
            if (turn_end) begin
                a_oe <= 1'b0;
            end
            if (access_end && !dir) begin
                rsp_rdata <= a_in;
            end
        end
    end

endmodule

// File: tb/tb_hc245_bus_seq.sv
module tb_hc245_bus_seq;

    logic       clk = 1'b0;
    logic       rst;

    // default-parameter instance
    logic       req_valid, req_write, req_ready, rsp_valid, dir, oe_n, a_oe;
    logic [7:0] req_wdata, rsp_rdata, a_out, a_in;

    // SETUP=2 / ACCESS=3 / TURN=2 instance
    logic       p_req_valid, p_req_write, p_req_ready, p_rsp_valid, p_dir, p_oe_n, p_a_oe;
    logic [7:0] p_req_wdata, p_rsp_rdata, p_a_out, p_a_in;

    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    hc245_bus_seq dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .dir(dir), .oe_n(oe_n), .a_out(a_out), .a_oe(a_oe), .a_in(a_in)
    );

    hc245_bus_seq #(.SETUP_CYC(2), .ACCESS_CYC(3), .TURN_CYC(2)) dut_p (
        .clk(clk), .rst(rst),
        .req_valid(p_req_valid), .req_ready(p_req_ready), .req_write(p_req_write), .req_wdata(p_req_wdata),
        .rsp_valid(p_rsp_valid), .rsp_rdata(p_rsp_rdata),
        .dir(p_dir), .oe_n(p_oe_n), .a_out(p_a_out), .a_oe(p_a_oe), .a_in(p_a_in)
    );

    // Advance one clock. Inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bus-safety invariants. They are checked on every falling edge once
    // the first reset has completed.
    task automatic monitor();
        logic r;
        logic prev_dir = 1'b0;
        logic prev_oe_n = 1'b1;
        logic prev_ok = 1'b0;
        forever begin
            @(posedge clk);
            r = rst;
            @(negedge clk);
            if (mon_en && !r) begin
                checks++;
                if (dir === 1'b0 && oe_n === 1'b0 && a_oe === 1'b1) begin
                    errors++;
                    $display("[TB] FAIL inv_contention: got dir=%b oe_n=%b a_oe=%b, required not 0/0/1", dir, oe_n, a_oe);
                end
                checks++;
                if (a_oe === 1'b1 && dir !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL inv_aoe_dir: got a_oe=%b dir=%b, required dir=1", a_oe, dir);
                end
                checks++;
                if (prev_ok && dir !== prev_dir && !(prev_oe_n === 1'b1 && oe_n === 1'b1)) begin
                    errors++;
                    $display("[TB] FAIL inv_dir_change: got oe_n %b->%b on dir change, required 1->1", prev_oe_n, oe_n);
                end
                checks++;
                if (p_dir === 1'b0 && p_oe_n === 1'b0 && p_a_oe === 1'b1) begin
                    errors++;
                    $display("[TB] FAIL inv_p_contention: got dir=%b oe_n=%b a_oe=%b", p_dir, p_oe_n, p_a_oe);
                end
                prev_ok = 1'b1;
            end else begin
                prev_ok = 1'b0;
            end
            prev_dir  = dir;
            prev_oe_n = oe_n;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_wdata = 8'h00; a_in = 8'h00;
        p_req_valid = 1'b0; p_req_write = 1'b0; p_req_wdata = 8'h00; p_a_in = 8'h00;
        step();
        step();
        checks++;
        if ({oe_n, dir, a_oe, rsp_valid, req_ready} !== 5'b10000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got oe_n,dir,a_oe,rsp_valid,req_ready=%b, required 10000",
                     {oe_n, dir, a_oe, rsp_valid, req_ready});
        end
        checks++;
        if (a_out !== 8'h00 || rsp_rdata !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_data: got a_out=%h rsp_rdata=%h, required 00/00", a_out, rsp_rdata);
        end
        checks++;
        if ({p_oe_n, p_dir, p_a_oe, p_rsp_valid, p_req_ready} !== 5'b10000) begin
            errors++;
            $display("[TB] FAIL reset_p_ctrl: got %b, required 10000",
                     {p_oe_n, p_dir, p_a_oe, p_rsp_valid, p_req_ready});
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release_ready: got %b, required 1", req_ready);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_write();
        logic [5:0] exp_v;
        req_valid = 1'b1; req_write = 1'b1; req_wdata = 8'hA5;
        step();  // E0
        req_valid = 1'b0; req_write = 1'b0; req_wdata = 8'h00;
        for (int k = 0; k <= 4; k++) begin
            // oe_n, rsp_valid, a_oe, req_ready, dir, (rsp_rdata still reset)
            exp_v = {~(k == 1 || k == 2), (k == 3), (k < 4), (k == 4), 1'b1, 1'b0};
            checks++;
            if ({oe_n, rsp_valid, a_oe, req_ready, dir, (rsp_rdata != 8'h00)} !== exp_v) begin
                errors++;
                $display("[TB] FAIL write_k%0d: got oe_n,rsp_valid,a_oe,req_ready,dir,rd!=0=%b, required %b",
                         k, {oe_n, rsp_valid, a_oe, req_ready, dir, (rsp_rdata != 8'h00)}, exp_v);
            end
            checks++;
            if (a_out !== 8'hA5) begin
                errors++;
                $display("[TB] FAIL write_aout_k%0d: got %h, required a5", k, a_out);
            end
            if (k < 4) step();
        end
    endtask

    task automatic test_read();
        logic [4:0] exp_v;
        logic [7:0] exp_rd;
        a_in = 8'h3C;
        req_valid = 1'b1; req_write = 1'b0; req_wdata = 8'h11;
        step();  // E0
        req_valid = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            exp_v  = {~(k == 1 || k == 2), (k == 3), 1'b0, (k == 4), 1'b0};
            exp_rd = (k >= 3) ? 8'h3C : 8'h00;
            checks++;
            if ({oe_n, rsp_valid, a_oe, req_ready, dir} !== exp_v) begin
                errors++;
                $display("[TB] FAIL read_k%0d: got oe_n,rsp_valid,a_oe,req_ready,dir=%b, required %b",
                         k, {oe_n, rsp_valid, a_oe, req_ready, dir}, exp_v);
            end
            checks++;
            if (rsp_rdata !== exp_rd) begin
                errors++;
                $display("[TB] FAIL read_rdata_k%0d: got %h, required %h", k, rsp_rdata, exp_rd);
            end
            if (k == 3) a_in = 8'hFF;
            if (k < 4) step();
        end
        step();
        step();
        checks++;
        if (rsp_rdata !== 8'h3C) begin
            errors++;
            $display("[TB] FAIL read_rdata_hold: got %h, required 3c", rsp_rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_v;
        a_in = 8'h77;
        req_valid = 1'b1; req_write = 1'b0; req_wdata = 8'h00;
        step();  // E0 of read
        req_write = 1'b1; req_wdata = 8'h5A;  // req_valid stays high
        for (int k = 0; k <= 4; k++) begin
            exp_v = {~(k == 1 || k == 2), (k == 3), 1'b0, (k == 4), 1'b0};
            checks++;
            if ({oe_n, rsp_valid, a_oe, req_ready, dir} !== exp_v) begin
                errors++;
                $display("[TB] FAIL b2b_read_k%0d: got %b, required %b", k, {oe_n, rsp_valid, a_oe, req_ready, dir}, exp_v);
            end
            if (k == 3) begin
                checks++;
                if (rsp_rdata !== 8'h77) begin
                    errors++;
                    $display("[TB] FAIL b2b_read_rdata: got %h, required 77", rsp_rdata);
                end
            end
            if (k < 4) step();
        end
        step();  // write accepted at the end of the IDLE cycle
        req_valid = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            exp_v = {~(k == 1 || k == 2), (k == 3), (k < 4), (k == 4), 1'b1};
            checks++;
            if ({oe_n, rsp_valid, a_oe, req_ready, dir} !== exp_v) begin
                errors++;
                $display("[TB] FAIL b2b_write_k%0d: got %b, required %b", k, {oe_n, rsp_valid, a_oe, req_ready, dir}, exp_v);
            end
            checks++;
            if (a_out !== 8'h5A || rsp_rdata !== 8'h77) begin
                errors++;
                $display("[TB] FAIL b2b_write_data_k%0d: got a_out=%h rdata=%h, required 5a/77", k, a_out, rsp_rdata);
            end
            if (k < 4) step();
        end
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_write = 1'b1; req_wdata = 8'hC3;
        step();  // E0
        req_valid = 1'b0;
        step();  // cycle E0+1, ACCESS
        checks++;
        if (oe_n !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_pre_oe_n: got %b, required 0", oe_n);
        end
        rst = 1'b1;
        step();  // edge E0+2 sampled with rst high
        checks++;
        if ({oe_n, a_oe, dir, rsp_valid, req_ready} !== 5'b10000) begin
            errors++;
            $display("[TB] FAIL rstmid_ctrl: got oe_n,a_oe,dir,rsp_valid,req_ready=%b, required 10000",
                     {oe_n, a_oe, dir, rsp_valid, req_ready});
        end
        checks++;
        if (a_out !== 8'h00 || rsp_rdata !== 8'h00) begin
            errors++;
            $display("[TB] FAIL rstmid_data: got a_out=%h rdata=%h, required 00/00", a_out, rsp_rdata);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstmid_ready: got %b, required 1", req_ready);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (rsp_valid !== 1'b0 || oe_n !== 1'b1) begin
                errors++;
                $display("[TB] FAIL rstmid_quiet_%0d: got rsp_valid=%b oe_n=%b, required 0/1", i, rsp_valid, oe_n);
            end
        end
    endtask

    task automatic test_params();
        logic [4:0] exp_v;
        logic [7:0] exp_rd;
        p_a_in = 8'h81;
        p_req_valid = 1'b1; p_req_write = 1'b0; p_req_wdata = 8'h00;
        step();  // E0
        p_req_valid = 1'b0;
        for (int k = 0; k <= 7; k++) begin
            exp_v  = {~(k >= 2 && k <= 4), (k == 5), 1'b0, (k == 7), 1'b0};
            exp_rd = (k >= 5) ? 8'h81 : 8'h00;
            checks++;
            if ({p_oe_n, p_rsp_valid, p_a_oe, p_req_ready, p_dir} !== exp_v) begin
                errors++;
                $display("[TB] FAIL params_k%0d: got oe_n,rsp_valid,a_oe,req_ready,dir=%b, required %b",
                         k, {p_oe_n, p_rsp_valid, p_a_oe, p_req_ready, p_dir}, exp_v);
            end
            checks++;
            if (p_rsp_rdata !== exp_rd) begin
                errors++;
                $display("[TB] FAIL params_rdata_k%0d: got %h, required %h", k, p_rsp_rdata, exp_rd);
            end
            if (k == 5) p_a_in = 8'h00;
            if (k < 7) step();
        end
    endtask

    task automatic test_random();
        logic [4:0] exp_v;
        logic [7:0] exp_rd = 8'h00;  // reset_mid left rsp_rdata cleared
        logic [7:0] cap = 8'h00;
        logic       exp_wr;
        logic [7:0] exp_wd;
        int         gap;
        int         rsp_count = 0;
        req_valid = 1'b0;
        for (int t = 0; t < 500; t++) begin
            if (req_valid !== 1'b1) begin
                gap = int'($urandom_range(0, 3));
                for (int g = 0; g < gap; g++) begin
                    a_in = 8'($urandom);
                    step();
                    checks++;
                    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                        errors++;
                        $display("[TB] FAIL rand_gap_t%0d: got rsp_valid=%b req_ready=%b, required 0/1", t, rsp_valid, req_ready);
                    end
                end
                req_valid = 1'b1; req_write = 1'($urandom); req_wdata = 8'($urandom);
            end
            checks++;
            if (req_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL rand_ready_t%0d: got %b, required 1", t, req_ready);
            end
            exp_wr = req_write;
            exp_wd = req_wdata;
            a_in = 8'($urandom);
            step();  // E0
            req_valid = 1'($urandom); req_write = 1'($urandom); req_wdata = 8'($urandom);
            for (int k = 0; k <= 3; k++) begin
                if (k == 3 && !exp_wr) exp_rd = cap;
                if (rsp_valid === 1'b1) rsp_count++;
                exp_v = {~(k == 1 || k == 2), (k == 3), exp_wr, 1'b0, exp_wr};
                checks++;
                if ({oe_n, rsp_valid, a_oe, req_ready, dir} !== exp_v) begin
                    errors++;
                    $display("[TB] FAIL rand_t%0d_k%0d: got oe_n,rsp_valid,a_oe,req_ready,dir=%b, required %b",
                             t, k, {oe_n, rsp_valid, a_oe, req_ready, dir}, exp_v);
                end
                checks++;
                if (rsp_rdata !== exp_rd || a_out !== exp_wd) begin
                    errors++;
                    $display("[TB] FAIL rand_data_t%0d_k%0d: got rdata=%h a_out=%h, required %h/%h",
                             t, k, rsp_rdata, a_out, exp_rd, exp_wd);
                end
                a_in = 8'($urandom);
                if (k == 2) cap = a_in;
                step();
            end
            checks++;
            if ({req_ready, a_oe, oe_n, rsp_valid, dir} !== {1'b1, 1'b0, 1'b1, 1'b0, exp_wr}) begin
                errors++;
                $display("[TB] FAIL rand_idle_t%0d: got req_ready,a_oe,oe_n,rsp_valid,dir=%b, required 1010%b",
                         t, {req_ready, a_oe, oe_n, rsp_valid, dir}, exp_wr);
            end
        end
        req_valid = 1'b0;
        checks++;
        if (rsp_count != 500) begin
            errors++;
            $display("[TB] FAIL rand_rsp_count: got %0d, required 500", rsp_count);
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid();
        test_params();
        test_random();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
